// File: rtl/adsr_pkg.sv
// adsr_pkg: shared types and constants for the ADSR envelope generator.
package adsr_pkg;

  // Envelope FSM state encodings.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  // Full-scale envelope value; the attack phase saturates here.
  localparam logic [15:0] ENV_MAX = 16'hFFFF;

endpackage

// File: rtl/env_scaler.sv
// env_scaler: two-stage sample x envelope gain stage.
// Stage 1 registers the signed product of the sample and the zero-extended
// envelope; stage 2 takes the arithmetic right shift by ENV_W_P and
// truncates to WIDTH_P. sample_o holds its value between valid pulses.
module env_scaler #(
  parameter int WIDTH_P = 24,
  parameter int ENV_W_P = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [WIDTH_P-1:0] sample_i,
  input  logic [ENV_W_P-1:0] env_i,
  output logic               valid_o,
  output logic [WIDTH_P-1:0] sample_o
);

  // A signed WIDTH_P sample times an unsigned ENV_W_P gain fits in
  // WIDTH_P+ENV_W_P signed bits, so the product never overflows.
  localparam int PROD_W = WIDTH_P + ENV_W_P;

  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] env_ext;
  logic signed [PROD_W-1:0] prod_q;
  logic                     valid_q;
  logic                     unused_lsbs;

  assign samp_ext    = PROD_W'($signed(sample_i));
  assign env_ext     = PROD_W'({1'b0, env_i});
  assign unused_lsbs = ^prod_q[ENV_W_P-1:0];

  // Stage 1: capture the full-precision product for each accepted sample.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) prod_q <= samp_ext * env_ext;
    end
  end

  // Stage 2: shift out the fractional gain bits and present the result.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sample_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= valid_q;
      if (valid_q) sample_o <= prod_q[ENV_W_P +: WIDTH_P];
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR envelope generator and gain stage, 48 kHz sample domain.
// Build option: define ADSR_EXP_RELEASE_EN for an exponential release
// (decrement = (env >> release_step_i[3:0]) + 1); otherwise the release
// decrement is release_step_i (linear).
//
// state   | meaning
// IDLE    | note off, env forced to 0
// ATTACK  | env rises by attack step, saturates at ENV_MAX
// DECAY   | env falls by decay step, floored at the sustain level
// SUSTAIN | env tracks the sustain level while the key is held
// RELEASE | key released, env falls toward 0
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int WIDTH_P = 24,
  parameter int ENV_W_P = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               sample_valid_i,
  input  logic [WIDTH_P-1:0] sample_i,
  input  logic               gate_i,
  input  logic [ENV_W_P-1:0] attack_step_i,
  input  logic [ENV_W_P-1:0] decay_step_i,
  input  logic [ENV_W_P-1:0] sustain_level_i,
  input  logic [ENV_W_P-1:0] release_step_i,
  output logic [WIDTH_P-1:0] sample_o,
  output logic               sample_valid_o,
  output logic [ENV_W_P-1:0] env_o,
  output logic [2:0]         state_o
);

  localparam logic [ENV_W_P-1:0] ENV_MAX_L = ENV_W_P'(ENV_MAX);

  adsr_state_t        state_q;
  logic [ENV_W_P-1:0] env_q;
  logic               gate_q;

  logic               gate_rise;
  logic               gate_fall;
  logic [ENV_W_P:0]   atk_sum;
  logic [ENV_W_P:0]   dec_diff;
  logic [ENV_W_P:0]   rel_dec;
  logic [ENV_W_P:0]   rel_diff;
  logic               atk_sat;
  logic               dec_floor;
  logic               rel_zero;

  assign gate_rise = gate_i & ~gate_q;
  assign gate_fall = ~gate_i & gate_q;

`ifdef ADSR_EXP_RELEASE_EN
  logic unused_rel;
  assign unused_rel = ^release_step_i[ENV_W_P-1:4];
`endif

  // Candidate next envelope values; the top bit of each sum/difference
  // flags carry (attack) or borrow (decay/release).
  always_comb begin
    atk_sum  = {1'b0, env_q} + {1'b0, attack_step_i};
    dec_diff = {1'b0, env_q} - {1'b0, decay_step_i};
`ifdef ADSR_EXP_RELEASE_EN
    rel_dec  = {1'b0, env_q >> release_step_i[3:0]} + (ENV_W_P+1)'(1);
`else
    rel_dec  = {1'b0, release_step_i};
`endif
    rel_diff  = {1'b0, env_q} - rel_dec;
    atk_sat   = atk_sum >= {1'b0, ENV_MAX_L};
    dec_floor = dec_diff[ENV_W_P] || (dec_diff[ENV_W_P-1:0] <= sustain_level_i);
    rel_zero  = rel_diff[ENV_W_P] || (rel_diff[ENV_W_P-1:0] == '0);
  end

  // Envelope FSM: advances once per accepted sample, holds otherwise.
  // A gate fall wins over the phase's own transition, but env still moves
  // as the current phase dictates; a retrigger from RELEASE keeps env.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      gate_q  <= 1'b0;
    end else if (sample_valid_i) begin
      gate_q <= gate_i;
      case (state_q)
        ST_IDLE: begin
          env_q <= '0;
          if (gate_rise) state_q <= ST_ATTACK;
        end
        ST_ATTACK: begin
          env_q <= atk_sat ? ENV_MAX_L : atk_sum[ENV_W_P-1:0];
          if (gate_fall)    state_q <= ST_RELEASE;
          else if (atk_sat) state_q <= ST_DECAY;
        end
        ST_DECAY: begin
          env_q <= dec_floor ? sustain_level_i : dec_diff[ENV_W_P-1:0];
          if (gate_fall)      state_q <= ST_RELEASE;
          else if (dec_floor) state_q <= ST_SUSTAIN;
        end
        ST_SUSTAIN: begin
          env_q <= sustain_level_i;
          if (gate_fall) state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (gate_rise) begin
            state_q <= ST_ATTACK;
          end else begin
            env_q <= rel_zero ? '0 : rel_diff[ENV_W_P-1:0];
            if (rel_zero) state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          env_q   <= '0;
        end
      endcase
    end
  end

  assign env_o   = env_q;
  assign state_o = state_q;

  // Gain stage sees env before this sample's update.
  env_scaler #(
    .WIDTH_P(WIDTH_P),
    .ENV_W_P(ENV_W_P)
  ) u_env_scaler (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .valid_i (sample_valid_i),
    .sample_i(sample_i),
    .env_i   (env_q),
    .valid_o (sample_valid_o),
    .sample_o(sample_o)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed sequence through every ADSR phase; enveloped
// samples are checked through a scoreboard queue with arrival cycle.
module tb_adsr_envelope;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        sample_valid_i;
  logic [23:0] sample_i;
  logic        gate_i;
  logic [15:0] attack_step_i;
  logic [15:0] decay_step_i;
  logic [15:0] sustain_level_i;
  logic [15:0] release_step_i;
  logic [23:0] sample_o;
  logic        sample_valid_o;
  logic [15:0] env_o;
  logic [2:0]  state_o;

  typedef struct {
    logic [23:0] val;
    int          cyc;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m_env = 16'h0;
  logic [23:0] last_exp = 24'h0;

  adsr_envelope dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .gate_i         (gate_i),
    .attack_step_i  (attack_step_i),
    .decay_step_i   (decay_step_i),
    .sustain_level_i(sustain_level_i),
    .release_step_i (release_step_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .env_o          (env_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [23:0] scale(input logic [23:0] s, input logic [15:0] e);
    logic signed [47:0] p;
    p = $signed({{24{s[23]}}, s}) * $signed({32'h0, e});
    return p[39:16];
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock; pops and compares any enveloped sample that appears.
  task automatic tick();
    sb_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    if (sample_valid_o === 1'b1) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_extra observed pulse at cycle %0d expected none", cyc);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        assert (sample_o === e.val) else begin
          errors++;
          $error("FAIL sb_sample observed %h expected %h", sample_o, e.val);
        end
        checks++;
        assert (cyc == e.cyc) else begin
          errors++;
          $error("FAIL sb_latency observed cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    sample_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  // One envelope update with its expected env/state afterwards.
  task automatic upd(input logic [23:0] s, input logic [15:0] e_env, input logic [2:0] e_st,
                     input string tag, input bit lit_en = 1'b0, input logic [23:0] lit = 24'h0);
    sb_t item;
    sample_valid_i = 1'b1;
    sample_i       = s;
    item.val = lit_en ? lit : scale(s, m_env);
    item.cyc = cyc + 2;
    sb_q.push_back(item);
    last_exp = item.val;
    tick();
    chk_val({tag, "_env"}, 32'(env_o), 32'(e_env));
    chk_val({tag, "_state"}, 32'(state_o), 32'(e_st));
    m_env = e_env;
    sample_valid_i = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    sample_valid_i  = 1'b0;
    sample_i        = 24'h0;
    gate_i          = 1'b1;
    attack_step_i   = 16'h1000;
    decay_step_i    = 16'h0100;
    sustain_level_i = 16'h8000;
    release_step_i  = 16'h0800;

    #23;
    chk_val("rst_env", 32'(env_o), 32'h0);
    chk_val("rst_state", 32'(state_o), 32'(S_IDLE));
    chk_val("rst_sample", 32'(sample_o), 32'h0);
    chk_val("rst_valid", 32'(sample_valid_o), 32'h0);
    tick();
    rst_n = 1'b1;

    upd(24'(32'h123456), 16'h0000, S_ATTACK, "first_rise");
    for (int k = 1; k <= 16; k++)
      upd(24'($urandom), (k == 16) ? 16'hFFFF : 16'(k * 32'h1000),
          (k == 16) ? S_DECAY : S_ATTACK, "attack");
    for (int k = 1; k <= 128; k++)
      upd(24'($urandom), (k == 128) ? 16'h8000 : 16'(32'hFFFF - k * 32'h100),
          (k == 128) ? S_SUSTAIN : S_DECAY, "decay");

    upd(24'h400000, 16'h8000, S_SUSTAIN, "scale_pos", 1'b1, 24'h200000);
    upd(24'hC00000, 16'h8000, S_SUSTAIN, "scale_neg", 1'b1, 24'hE00000);
    idle(4);
    chk_val("hold_sample", 32'(sample_o), 32'h00E00000);
    chk_val("hold_valid", 32'(sample_valid_o), 32'h0);
    chk_val("hold_env", 32'(env_o), 32'h8000);

    sustain_level_i = 16'h4000;
    upd(24'($urandom), 16'h4000, S_SUSTAIN, "sustain_track");
    sustain_level_i = 16'h8000;
    upd(24'($urandom), 16'h8000, S_SUSTAIN, "sustain_back");

    gate_i = 1'b0;
    upd(24'($urandom), 16'h8000, S_RELEASE, "fall_sustain");
`ifndef ADSR_EXP_RELEASE_EN
    for (int k = 1; k <= 16; k++)
      upd(24'($urandom), 16'(32'h8000 - k * 32'h800), (k == 16) ? S_IDLE : S_RELEASE, "rel_lin");
`else
    release_step_i = 16'h0004;
    for (int k = 0; k < 400 && m_env != 16'h0; k++) begin
      logic [15:0] d;
      d = 16'((m_env >> 4) + 16'h1);
      upd(24'($urandom), (d >= m_env) ? 16'h0 : 16'(m_env - d),
          (d >= m_env) ? S_IDLE : S_RELEASE, "rel_exp");
    end
`endif
    upd(24'($urandom), 16'h0000, S_IDLE, "idle_hold");

    gate_i        = 1'b1;
    attack_step_i = 16'hFFFF;
    upd(24'($urandom), 16'h0000, S_ATTACK, "rise2");
    upd(24'($urandom), 16'hFFFF, S_DECAY, "atk_max");
    decay_step_i = 16'h8000;
    upd(24'($urandom), 16'h8000, S_SUSTAIN, "dec_big");
    gate_i = 1'b0;
    upd(24'($urandom), 16'h8000, S_RELEASE, "fall2");
`ifndef ADSR_EXP_RELEASE_EN
    for (int k = 1; k <= 8; k++)
      upd(24'($urandom), 16'(32'h8000 - k * 32'h800), S_RELEASE, "rel_part");
    gate_i = 1'b1;
    upd(24'($urandom), 16'h4000, S_ATTACK, "retrig");
    attack_step_i = 16'h0000;
    upd(24'($urandom), 16'h4000, S_ATTACK, "atk_zero");
    upd(24'($urandom), 16'h4000, S_ATTACK, "atk_zero");
    attack_step_i = 16'h1000;
    for (int k = 1; k <= 11; k++)
      upd(24'($urandom), 16'(32'h4000 + k * 32'h1000), S_ATTACK, "atk_resume");
    gate_i = 1'b0;
    upd(24'($urandom), 16'hFFFF, S_RELEASE, "fall_sat");
    for (int k = 1; k <= 32; k++)
      upd(24'($urandom), (k == 32) ? 16'h0 : 16'(32'hFFFF - k * 32'h800),
          (k == 32) ? S_IDLE : S_RELEASE, "rel_full");
`else
    for (int k = 0; k < 400 && m_env != 16'h0; k++) begin
      logic [15:0] d;
      d = 16'((m_env >> 4) + 16'h1);
      upd(24'($urandom), (d >= m_env) ? 16'h0 : 16'(m_env - d),
          (d >= m_env) ? S_IDLE : S_RELEASE, "rel_exp2");
    end
`endif

    gate_i        = 1'b1;
    attack_step_i = 16'hFFFF;
    decay_step_i  = 16'h0100;
    upd(24'($urandom), 16'h0000, S_ATTACK, "rise3");
    upd(24'($urandom), 16'hFFFF, S_DECAY, "atk3");
    upd(24'($urandom), 16'hFEFF, S_DECAY, "dec3");
    upd(24'h300000, 16'hFDFF, S_DECAY, "dec3");
    idle(3);
    chk_val("pre_reset_sample", 32'(sample_o), 32'(last_exp));
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_env", 32'(env_o), 32'h0);
    chk_val("async_rst_state", 32'(state_o), 32'(S_IDLE));
    chk_val("async_rst_sample", 32'(sample_o), 32'h0);
    chk_val("async_rst_valid", 32'(sample_valid_o), 32'h0);
    m_env = 16'h0;
    tick();
    rst_n = 1'b1;
    upd(24'($urandom), 16'h0000, S_ATTACK, "rst_rise");
    upd(24'($urandom), 16'hFFFF, S_DECAY, "rst_atk");

    idle(4);
    chk_val("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
